memwb_writeback: RTL and testbench
==================================

MEMWB_WRITEBACK -- requirements
Module: memwb_writeback

Interface
REQ-001 Parameter TIMEOUT, default 15; number of LWAIT cycles without DmemAck before a load is abandoned.
REQ-002 CLK  in  1  pipeline clock; all state updates on rising edge.
REQ-003 RSTB  in  1  reset, synchronous, active-low.
REQ-004 InValid  in  1  upstream (EX/MEM) instruction valid.
REQ-005 InALUOUT  in  32  ALU result; load address for loads.
REQ-006 InPC  in  32  PC of the instruction.
REQ-007 Inrd  in  5  destination register index.
REQ-008 InRegWrite  in  1  instruction writes the regfile.
REQ-009 InDmem1ALUOUT  in  1  1 = load (write data from memory), 0 = ALU/link result.
REQ-010 InLinkPC  in  1  1 = write PC+4 (jal/jalr link); ignored when InDmem1ALUOUT=1.
REQ-011 InFunct3  in  3  load size/sign code.
REQ-012 DmemRdata  in  32  data memory read word.
REQ-013 DmemAck  in  1  data memory read data valid.
REQ-014 Stall  out  1  upstream must hold its inputs.
REQ-015 RegWrite  out  1  regfile write enable.
REQ-016 rd  out  5  regfile write index.
REQ-017 indata  out  32  regfile write data.
REQ-018 WBValid  out  1  one-cycle pulse per retired instruction.
REQ-019 LoadErr  out  1  one-cycle pulse per abandoned or illegal load.

Function
REQ-020 FSM states IDLE and LWAIT; 4-bit wait counter; Stall = (state==LWAIT), combinational from state.
REQ-021 IDLE, InValid=1, InDmem1ALUOUT=0: next edge RegWrite=InRegWrite&(Inrd!=0), rd=Inrd, indata=InLinkPC?InPC+4 (mod 2^32):InALUOUT, WBValid=1; state stays IDLE.
REQ-022 IDLE, InValid=0: next edge RegWrite=0, WBValid=0, LoadErr=0; rd/indata hold.
REQ-023 IDLE, InValid=1, InDmem1ALUOUT=1: capture Inrd, InRegWrite, InFunct3, InALUOUT[1:0]; counter=0; next state LWAIT; RegWrite=0 that edge.
REQ-024 DmemAck sampled only in LWAIT; DmemAck in IDLE ignored.
REQ-025 LWAIT, DmemAck=1: next edge write extracted data, state IDLE, WBValid=1; Stall deasserts that same edge.
REQ-026 Extraction: 000 lb byte[off] sign-ext; 001 lh half[off[1]] sign-ext; 010 lw full word; 100 lbu byte[off] zero-ext; 101 lhu half[off[1]] zero-ext; off = captured ALUOUT[1:0]; misaligned low bits beyond size ignored.
REQ-027 Funct3 011/110/111 on ack: RegWrite=0, WBValid=0, LoadErr=1, state IDLE.
REQ-028 Load write enable = captured InRegWrite & (captured rd!=0); WBValid still pulses for rd=0.
REQ-029 LWAIT, DmemAck=0: counter increments; when counter reaches TIMEOUT-1 with no ack, next edge LoadErr=1, RegWrite=0, state IDLE; ack on that same final cycle takes priority (normal retire).
REQ-030 RegWrite, WBValid, LoadErr are single-cycle pulses; never high simultaneously with each other except RegWrite with WBValid.
REQ-031 Inputs other than DmemRdata/DmemAck ignored while in LWAIT.

Reset
REQ-032 RSTB=0 at a rising edge: state IDLE, counter 0, RegWrite=0, WBValid=0, LoadErr=0, rd=0, indata=0, Stall=0.
REQ-033 Reset during LWAIT drops the pending load with no write and no LoadErr.
REQ-034 Reset has priority over every other input at the same edge.

Verification
REQ-035 ALU op InALUOUT=0x0000_1234, Inrd=5, InRegWrite=1 -> next cycle RegWrite=1, rd=5, indata=0x0000_1234, WBValid=1.
REQ-036 jal InPC=0x0000_0100, InLinkPC=1, Inrd=1 -> indata=0x0000_0104; InPC=0xFFFF_FFFC -> indata=0x0000_0000.
REQ-037 lb, ALUOUT[1:0]=3, ack after 2 cycles with DmemRdata=0x80FF_FFFF -> Stall high 3 cycles, then indata=0xFFFF_FF80; lbu same -> 0x0000_0080.
REQ-038 lh off=2 with 0x8001_0000 -> 0xFFFF_8001; Inrd=0 load -> RegWrite=0, WBValid=1.
REQ-039 Load never acked -> after 15 LWAIT cycles LoadErr pulses, RegWrite=0, Stall falls; ack on the 15th cycle -> normal write, no LoadErr.
REQ-040 RSTB=0 in LWAIT cycle 3 -> next edge Stall=0, all outputs zero; later stray DmemAck causes no write.

Source files
------------

// File: rtl/memwb_writeback.sv
// memwb_writeback
//   MEM/WB writeback stage. ALU and link results retire on the edge after
//   they are presented. Loads park the stage in LWAIT until the data memory
//   acknowledges or the wait budget runs out. Upstream is held by o_stall
//   while a load is outstanding.
//
// Ports
//   i_clk, i_rstb          pipeline clock, synchronous active-low reset
//   i_in_valid             EX/MEM instruction valid
//   i_in_aluout            ALU result / load address
//   i_in_pc                instruction PC (link value is PC+4)
//   i_in_rd                destination register index
//   i_in_reg_write         instruction writes the regfile
//   i_in_dmem1aluout       1 = load, 0 = ALU/link result
//   i_in_link_pc           1 = write PC+4 (ignored for loads)
//   i_in_funct3            load size/sign code
//   i_dmem_rdata           data memory read word
//   i_dmem_ack             read data valid (looked at only in LWAIT)
//   o_stall                upstream must hold its inputs
//   o_reg_write            regfile write enable (pulse)
//   o_rd, o_indata         regfile write index / data
//   o_wb_valid             pulse per retired instruction
//   o_load_err             pulse per abandoned or illegal load
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting instructions; ALU/link results retire directly
// LWAIT | load outstanding; waiting for ack, counting toward timeout

module memwb_writeback #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rstb,
    input  logic        i_in_valid,
    input  logic [31:0] i_in_aluout,
    input  logic [31:0] i_in_pc,
    input  logic [4:0]  i_in_rd,
    input  logic        i_in_reg_write,
    input  logic        i_in_dmem1aluout,
    input  logic        i_in_link_pc,
    input  logic [2:0]  i_in_funct3,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_ack,
    output logic        o_stall,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [31:0] o_indata,
    output logic        o_wb_valid,
    output logic        o_load_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_LWAIT = 1'b1
    } state_t;

    // Terminal count: the last LWAIT cycle that may still accept an ack.
    localparam logic [3:0] TC = 4'(TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [4:0]  r_ld_rd;
    logic        r_ld_we;
    logic [2:0]  r_ld_f3;
    logic [1:0]  r_ld_off;
    logic        r_reg_write;
    logic [4:0]  r_rd;
    logic [31:0] r_indata;
    logic        r_wb_valid;
    logic        r_load_err;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_f3_legal;

    // Low address bits beyond the access size are simply ignored.
    always_comb begin
        w_byte = 8'h00;
        case (r_ld_off)
            2'd0: w_byte = i_dmem_rdata[7:0];
            2'd1: w_byte = i_dmem_rdata[15:8];
            2'd2: w_byte = i_dmem_rdata[23:16];
            2'd3: w_byte = i_dmem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_ld_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

        w_f3_legal  = 1'b1;
        w_load_data = 32'h0;
        case (r_ld_f3)
            3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001: w_load_data = {{16{w_half[15]}}, w_half};
            3'b010: w_load_data = i_dmem_rdata;
            3'b100: w_load_data = {24'h0, w_byte};
            3'b101: w_load_data = {16'h0, w_half};
            default: w_f3_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_ld_rd     <= 5'd0;
            r_ld_we     <= 1'b0;
            r_ld_f3     <= 3'd0;
            r_ld_off    <= 2'd0;
            r_reg_write <= 1'b0;
            r_rd        <= 5'd0;
            r_indata    <= 32'h0;
            r_wb_valid  <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        if (i_in_dmem1aluout) begin
                            r_ld_rd  <= i_in_rd;
                            r_ld_we  <= i_in_reg_write & (i_in_rd != 5'd0);
                            r_ld_f3  <= i_in_funct3;
                            r_ld_off <= i_in_aluout[1:0];
                            r_cnt    <= 4'd0;
                            r_state  <= S_LWAIT;
                        end else begin
                            r_reg_write <= i_in_reg_write & (i_in_rd != 5'd0);
                            r_rd        <= i_in_rd;
                            r_indata    <= i_in_link_pc ? (i_in_pc + 32'd4) : i_in_aluout;
                            r_wb_valid  <= 1'b1;
                        end
                    end
                end
                S_LWAIT: begin
                    // An ack on the terminal-count cycle wins over the timeout.
                    if (i_dmem_ack) begin
                        r_state <= S_IDLE;
                        if (w_f3_legal) begin
                            r_reg_write <= r_ld_we;
                            r_rd        <= r_ld_rd;
                            r_indata    <= w_load_data;
                            r_wb_valid  <= 1'b1;
                        end else begin
                            r_load_err  <= 1'b1;
                        end
                    end else if (r_cnt == TC) begin
                        r_state    <= S_IDLE;
                        r_load_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall     = (r_state == S_LWAIT);
    assign o_reg_write = r_reg_write;
    assign o_rd        = r_rd;
    assign o_indata    = r_indata;
    assign o_wb_valid  = r_wb_valid;
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_memwb_writeback.sv
module tb_memwb_writeback;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rstb;
    logic        in_valid;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rw;
    logic        in_dm;
    logic        in_link;
    logic [2:0]  in_f3;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dut_stall;
    logic        dut_rw;
    logic [4:0]  dut_rd;
    logic [31:0] dut_data;
    logic        dut_wbv;
    logic        dut_err;

    memwb_writeback #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk            (clk),
        .i_rstb           (rstb),
        .i_in_valid       (in_valid),
        .i_in_aluout      (in_alu),
        .i_in_pc          (in_pc),
        .i_in_rd          (in_rd),
        .i_in_reg_write   (in_rw),
        .i_in_dmem1aluout (in_dm),
        .i_in_link_pc     (in_link),
        .i_in_funct3      (in_f3),
        .i_dmem_rdata     (dm_rdata),
        .i_dmem_ack       (dm_ack),
        .o_stall          (dut_stall),
        .o_reg_write      (dut_rw),
        .o_rd             (dut_rd),
        .o_indata         (dut_data),
        .o_wb_valid       (dut_wbv),
        .o_load_err       (dut_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending-load record plus a count of cycles waited.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic [4:0]  m_rd;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_wbv;
    logic        exp_err;

    function automatic bit f3_ok(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        int          boff;
        int          hoff;
        boff = 8 * int'(off);
        hoff = 16 * (int'(off) / 2);
        b = (w >> boff) & 32'hFF;
        h = (w >> hoff) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        if (!rstb) begin
            m_busy = 1'b0;
            m_wait = 0;
            exp_rw = 1'b0; exp_wbv = 1'b0; exp_err = 1'b0;
            exp_rd = 5'd0; exp_data = 32'h0;
        end else begin
            exp_rw = 1'b0; exp_wbv = 1'b0; exp_err = 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (in_dm) begin
                        m_busy = 1'b1; m_wait = 0;
                        m_rd = in_rd; m_we = in_rw; m_f3 = in_f3; m_off = in_alu[1:0];
                    end else begin
                        exp_rw   = in_rw && (in_rd != 5'd0);
                        exp_rd   = in_rd;
                        exp_data = in_link ? in_pc + 32'd4 : in_alu;
                        exp_wbv  = 1'b1;
                    end
                end
            end else begin
                m_wait++;
                if (dm_ack) begin
                    m_busy = 1'b0;
                    if (f3_ok(m_f3)) begin
                        exp_rw   = m_we && (m_rd != 5'd0);
                        exp_rd   = m_rd;
                        exp_data = extract(m_f3, m_off, dm_rdata);
                        exp_wbv  = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                end else if (m_wait == TIMEOUT) begin
                    m_busy  = 1'b0;
                    exp_err = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, " stall"}, 32'(dut_stall), 32'(m_busy));
        chk({tag, " regwrite"}, 32'(dut_rw), 32'(exp_rw));
        chk({tag, " rd"}, 32'(dut_rd), 32'(exp_rd));
        chk({tag, " indata"}, dut_data, exp_data);
        chk({tag, " wbvalid"}, 32'(dut_wbv), 32'(exp_wbv));
        chk({tag, " loaderr"}, 32'(dut_err), 32'(exp_err));
    endtask

    task automatic drive(input logic v, input logic dm, input logic link, input logic rw,
                         input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc);
        in_valid = v; in_dm = dm; in_link = link; in_rw = rw;
        in_rd = rd; in_f3 = f3; in_alu = alu; in_pc = pc;
    endtask

    task automatic run_load(input string nm, input logic [2:0] f3, input logic [1:0] off,
                            input logic [4:0] rd, input logic we, input int n_wait,
                            input logic [31:0] rdata, input logic [31:0] e_data,
                            input logic e_rw);
        int stall_cnt;
        stall_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, we, rd, f3, {28'h0001_234, 2'b00, off}, 32'h0000_0200);
        tick({nm, " issue"});
        if (dut_stall) stall_cnt++;
        // Upstream noise while stalled must be ignored.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 3'd0, $urandom, $urandom);
        dm_ack = 1'b0;
        for (int i = 0; i < n_wait; i++) begin
            tick({nm, " wait"});
            if (dut_stall) stall_cnt++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
        dm_ack = 1'b1; dm_rdata = rdata;
        tick({nm, " ack"});
        dm_ack = 1'b0;
        chk({nm, " data"}, dut_data, e_data);
        chk({nm, " rw"}, 32'(dut_rw), 32'(e_rw));
        chk({nm, " wbv"}, 32'(dut_wbv), 32'd1);
        chk({nm, " rd"}, 32'(dut_rd), 32'(rd));
        chk({nm, " stall cycles"}, 32'(stall_cnt), 32'(n_wait + 1));
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        link;
        logic        e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_wbv;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1234, 32'h0,         5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b1};
        vecs[1] = '{1'b1, 32'h0,         32'h0000_0100, 5'd1, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0000_0104, 1'b1};
        vecs[2] = '{1'b1, 32'h0,         32'hFFFF_FFFC, 5'd1, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 32'h5555_AAAA, 32'h1111_0000, 5'd8, 1'b1, 1'b0, 1'b0, 5'd1, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_DEAD, 32'h0,         5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_DEAD, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0005, 32'h0,         5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_0005, 1'b1};

        rstb = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
        tick("reset");
        tick("reset");
        chk("reset stall", 32'(dut_stall), 32'd0);
        chk("reset indata", dut_data, 32'h0);
        rstb = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, 1'b0, vecs[i].link, vecs[i].rw, vecs[i].rd, 3'd0,
                  vecs[i].alu, vecs[i].pc);
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl rw", i), 32'(dut_rw), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d tbl rd", i), 32'(dut_rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d tbl data", i), dut_data, vecs[i].e_data);
            chk($sformatf("vec%0d tbl wbv", i), 32'(dut_wbv), 32'(vecs[i].e_wbv));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
        tick("idle");

        run_load("lb",   3'd0, 2'd3, 5'd6,  1'b1, 2, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b1);
        run_load("lbu",  3'd4, 2'd3, 5'd6,  1'b1, 2, 32'h80FF_FFFF, 32'h0000_0080, 1'b1);
        run_load("lh",   3'd1, 2'd2, 5'd10, 1'b1, 1, 32'h8001_0000, 32'hFFFF_8001, 1'b1);
        run_load("lhu",  3'd5, 2'd3, 5'd10, 1'b1, 0, 32'h8001_0000, 32'h0000_8001, 1'b1);
        run_load("lw",   3'd2, 2'd1, 5'd31, 1'b1, 3, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1);
        run_load("lb+",  3'd0, 2'd1, 5'd3,  1'b1, 1, 32'h0000_7F00, 32'h0000_007F, 1'b1);
        run_load("ldx0", 3'd2, 2'd0, 5'd0,  1'b1, 1, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);
        run_load("ldnw", 3'd2, 2'd0, 5'd4,  1'b0, 1, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0);

        // Never acked: abandoned after TIMEOUT waiting cycles.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 3'd2, 32'h100, 32'h0);
        tick("to issue");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick("to wait");
            chk("to wait stall", 32'(dut_stall), 32'd1);
            chk("to wait err", 32'(dut_err), 32'd0);
        end
        tick("to expire");
        chk("to err", 32'(dut_err), 32'd1);
        chk("to rw", 32'(dut_rw), 32'd0);
        chk("to wbv", 32'(dut_wbv), 32'd0);
        chk("to stall", 32'(dut_stall), 32'd0);
        tick("to after");
        chk("to err pulse", 32'(dut_err), 32'd0);

        // Ack on the final allowed cycle retires normally.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 3'd2, 32'h104, 32'h0);
        tick("late issue");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
        for (int i = 1; i < TIMEOUT; i++) tick("late wait");
        dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
        tick("late ack");
        dm_ack = 1'b0;
        chk("late rw", 32'(dut_rw), 32'd1);
        chk("late err", 32'(dut_err), 32'd0);
        chk("late data", dut_data, 32'h1234_5678);

        // Illegal size code on ack.
        run_illegal();

        // Reset in LWAIT cycle 3 drops the load; a stray ack later does nothing.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd14, 3'd2, 32'h108, 32'h0);
        tick("rl issue");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
        tick("rl w1");
        tick("rl w2");
        rstb = 1'b0;
        tick("rl reset");
        chk("rl stall", 32'(dut_stall), 32'd0);
        chk("rl data", dut_data, 32'h0);
        chk("rl err", 32'(dut_err), 32'd0);
        rstb = 1'b1;
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        tick("rl stray");
        tick("rl stray");
        chk("rl stray rw", 32'(dut_rw), 32'd0);
        chk("rl stray wbv", 32'(dut_wbv), 32'd0);
        dm_ack = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rstb     = ($urandom_range(0, 199) != 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_dm    = $urandom_range(0, 2) == 0;
            in_link  = $urandom_range(0, 1) == 1;
            in_rw    = $urandom_range(0, 3) != 0;
            in_rd    = 5'($urandom_range(0, 31));
            in_f3    = 3'($urandom_range(0, 7));
            in_alu   = $urandom;
            in_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            dm_ack   = $urandom_range(0, 5) == 0;
            dm_rdata = $urandom;
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic run_illegal();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd15, 3'd3, 32'h10C, 32'h0);
        tick("ill issue");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
        dm_ack = 1'b1; dm_rdata = 32'hAAAA_5555;
        tick("ill ack");
        dm_ack = 1'b0;
        chk("ill err", 32'(dut_err), 32'd1);
        chk("ill rw", 32'(dut_rw), 32'd0);
        chk("ill wbv", 32'(dut_wbv), 32'd0);
        chk("ill stall", 32'(dut_stall), 32'd0);
    endtask

endmodule
